md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit with HI/LO registers, sitting in the Execute stage beside the ALU. It consumes the 3-bit MD operation code and HI/LO read select produced by the instruction decoder, and runs mult/multu/div/divu over a configurable number of cycles. While an operation is running it raises `busy`; the hazard logic uses `busy` to stall any following HI/LO instruction. mthi/mtlo writes are single-cycle.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥1.
- `clk` input 1: clock; one clock domain, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: E-stage instruction valid for the MD unit this cycle.
- `MDop` input 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op).
- `flush` input 1: exception/interrupt in this cycle; suppresses issue.
- `A` input WIDTH: rs value (dividend, multiplicand, mthi/mtlo data).
- `B` input WIDTH: rt value (divisor, multiplier).
- `HILO_Rop` input 2: 01 selects HI, 10 selects LO, others select 0.
- `busy` output 1: multi-cycle operation in progress.
- `HI` output WIDTH: HI register.
- `LO` output WIDTH: LO register.
- `rdata` output WIDTH: combinational mux of HI/LO/0 per `HILO_Rop`, for mfhi/mflo.

## Operation
- Issue condition: `start & !flush & !busy` with `MDop` in 001–110.
- Issue with 001–100:
  - Latch A, B and op.
  - Load the cycle counter with the op's latency.
  - Set `busy`.
- Issue with 101 or 110: write A to HI or LO at that edge; `busy` stays 0.
- `start` while `busy`: ignored. HI/LO and the running operation are unaffected. The pipeline guarantees this does not occur; the bench checks it anyway.
- `flush` suppresses issue in the same cycle only. An operation already running completes and writes HI/LO.
- mult: {HI,LO} = signed A × signed B, full 2·WIDTH product.
- multu: {HI,LO} = unsigned A × unsigned B.
- div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- div overflow (most-negative ÷ −1): LO = 1<<(WIDTH−1), HI = 0.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (div/divu): HI and LO are left unchanged. Latency depends on the Configuration macro.
- The result may be produced by an iterative or combinational datapath. Only the visibility timing below is normative.
- States: IDLE (busy=0) and RUN (busy=1, counter>0).
  - IDLE→RUN on a mult/div issue.
  - RUN→IDLE on the edge where the counter reaches 1; HI/LO are written on that same edge.

## Timing
- Reset values: `busy`=0, HI=0, LO=0, counter=0; `rdata` follows the mux.
- Reset in RUN aborts the operation and returns the unit to reset values next cycle. No HI/LO write occurs.
- Issue in cycle t with latency N:
  - `busy`=1 in cycles t+1 … t+N.
  - HI/LO carry the new value, with `busy`=0, from cycle t+N+1.
- Back-to-back: a new issue is accepted in cycle t+N+1 at the earliest.
- mthi/mtlo issued in cycle t: value is visible on HI/LO and `rdata` in cycle t+1.
- `rdata` has no internal bypass: mfhi in the same cycle as mthi returns the old value.

## Configuration
- `MD_DIV0_FAST_EN` defined: div/divu with B=0 complete in 1 cycle. `busy` is high only in t+1; HI/LO are unchanged.
- `MD_DIV0_FAST_EN` undefined: divide by zero runs the full DIV_CYCLES with `busy` high, then leaves HI/LO unchanged.

## Test plan
- mult A=0xFFFFFFFF, B=2 → busy for cycles t+1..t+5; from t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678 in cycle t → HI=0x12345678 in t+1 and busy stays 0. mflo (`HILO_Rop`=10) → `rdata`=LO; `HILO_Rop`=00 → `rdata`=0.
- Issue multu, then mtlo 0xAAAA5555 while busy → mtlo ignored; LO holds the multu result after completion. `start`+`flush` with div → busy never rises and HI/LO are unchanged.
- div with B=0 and HI=LO=0x11111111 → HI/LO unchanged. Busy lasts 1 cycle with `MD_DIV0_FAST_EN` defined, 10 cycles without.
- Reset asserted in the 3rd busy cycle of a mult → next cycle busy=0 and HI=LO=0, with no later write.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the Execute stage; optional macro MD_DIV0_FAST_EN.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES (1 for divide-by-zero when MD_DIV0_FAST_EN); mthi/mtlo 1 cycle.
// Backpressure: busy is high while an operation runs; start during busy is ignored and must be stalled upstream.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDop,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       HILO_Rop,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] rdata
);

  // Operation codes from the instruction decoder.
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  // HI/LO read selects.
  localparam logic [1:0] RD_HI = 2'b01;
  localparam logic [1:0] RD_LO = 2'b10;

  // The counter must hold the longest latency.
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lat;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               issue;
  logic               issue_md;
  logic               issue_mthi;
  logic               issue_mtlo;
  logic               done;
  logic               md_wr;
  logic               is_div_op;
  logic               div0;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_mag_safe;
  logic [WIDTH-1:0]   b_u_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   rem_u;
  logic [2*WIDTH-1:0] result;

  // Issue decode: a new instruction is only taken when idle and not flushed.
  always_comb begin
    issue      = start & ~flush & ~busy;
    issue_md   = 1'b0;
    issue_mthi = 1'b0;
    issue_mtlo = 1'b0;
    case (MDop)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: issue_md   = issue;
      OP_MTHI:                            issue_mthi = issue;
      OP_MTLO:                            issue_mtlo = issue;
      default: ;
    endcase
  end

  // Latency of the operation being issued; a zero divisor may short-circuit.
  always_comb begin
    lat = '0;
    case (MDop)
      OP_MULT, OP_MULTU: lat = CNT_W'(MULT_CYCLES);
      OP_DIV, OP_DIVU: begin
`ifdef MD_DIV0_FAST_EN
        lat = (B == '0) ? CNT_W'(1) : CNT_W'(DIV_CYCLES);
`else
        lat = CNT_W'(DIV_CYCLES);
`endif
      end
      default: lat = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: run from issue until the counter's final cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue_md) state_nxt = S_RUN;
      S_RUN:  if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy while running, completion on the counter's last cycle.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    md_wr = 1'b0;
    case (state)
      S_RUN: begin
        busy  = 1'b1;
        done  = (cnt == CNT_W'(1));
        // A zero divisor finishes the op but leaves HI/LO as they were.
        md_wr = done & ~(is_div_op & div0);
      end
      default: ;
    endcase
  end

  // Cycle counter: loaded on issue, counts down while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (issue_md) begin
      cnt <= lat;
    end else if (busy && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand/op capture so the datapath is stable for the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (issue_md) begin
      op_q <= MDop;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Multiplier: sign-extend to full product width so the low 2*WIDTH bits are exact.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // Divider: signed divide via magnitudes; truncation toward zero, remainder takes dividend sign.
  // Most-negative / -1 falls out naturally: magnitude quotient 1<<(WIDTH-1), no negation, remainder 0.
  // Divisors of zero are replaced by one purely to keep the operator defined; the result is discarded.
  always_comb begin
    is_div_op  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div0       = (b_q == '0);
    a_neg      = a_q[WIDTH-1];
    b_neg      = b_q[WIDTH-1];
    a_mag      = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag      = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    b_mag_safe = div0 ? WIDTH'(1) : b_mag;
    b_u_safe   = div0 ? WIDTH'(1) : b_q;
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    quot_s     = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem_s      = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    quot_u     = a_q / b_u_safe;
    rem_u      = a_q % b_u_safe;
  end

  // Result select as {HI, LO}.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {rem_s, quot_s};
      OP_DIVU:  result = {rem_u, quot_u};
      default:  result = '0;
    endcase
  end

  // HI/LO registers: completion writes both; mthi/mtlo write one in a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (md_wr) begin
      HI <= result[2*WIDTH-1:WIDTH];
      LO <= result[WIDTH-1:0];
    end else if (issue_mthi) begin
      HI <= A;
    end else if (issue_mtlo) begin
      LO <= A;
    end
  end

  // mfhi/mflo read mux; no bypass from a same-cycle mthi/mtlo.
  always_comb begin
    case (HILO_Rop)
      RD_HI:   rdata = HI;
      RD_LO:   rdata = LO;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: reset, mult/div results and timing, mthi/mtlo, hazards.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours MD_DIV0_FAST_EN for the expected divide-by-zero latency.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDop;
  logic        flush;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  HILO_Rop;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MD_DIV0_FAST_EN
  localparam int DIV0_CYC = 1;
`else
  localparam int DIV0_CYC = 10;
`endif

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop), .flush(flush),
    .A(A), .B(B), .HILO_Rop(HILO_Rop), .busy(busy), .HI(HI), .LO(LO), .rdata(rdata)
  );

  // Issue one op at the current falling edge and count busy cycles until busy drops (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
    start = 1'b1; MDop = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDop = 3'b000; A = '0; B = '0;
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
  endtask

  // Load HI then LO through mthi/mtlo.
  task automatic load_hilo(input logic [31:0] hi, input logic [31:0] lo);
    start = 1'b1; MDop = 3'b101; A = hi;
    @(negedge clk);
    MDop = 3'b110; A = lo;
    @(negedge clk);
    start = 1'b0; MDop = 3'b000; A = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (HI !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", LO); end
    HILO_Rop = 2'b01; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    HILO_Rop = 2'b00;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int nb;
    run_op(3'b001, 32'hFFFFFFFF, 32'h2, nb);
    n_cmp++; if (nb !== 5) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    n_cmp++; if (LO !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffe", LO); end
    run_op(3'b010, 32'hFFFFFFFF, 32'h2, nb);
    n_cmp++; if (nb !== 5) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 5", nb); end
    n_cmp++; if (HI !== 32'h1) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", HI); end
    n_cmp++; if (LO !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", LO); end
  endtask

  task automatic test_div();
    int nb;
    run_op(3'b011, 32'hFFFFFFF9, 32'h2, nb);
    n_cmp++; if (nb !== 10) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 10", nb); end
    n_cmp++; if (LO !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_lo: got %h want fffffffd", LO); end
    n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_hi: got %h want ffffffff", HI); end
    // 7 / -2 = -3 remainder 1 (dividend positive)
    run_op(3'b011, 32'h7, 32'hFFFFFFFE, nb);
    n_cmp++; if (LO !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_negdvs_lo: got %h want fffffffd", LO); end
    n_cmp++; if (HI !== 32'h1) begin n_bad++; $display("FAIL div_negdvs_hi: got %h want 00000001", HI); end
    run_op(3'b100, 32'h7, 32'h2, nb);
    n_cmp++; if (nb !== 10) begin n_bad++; $display("FAIL divu_busy_cycles: got %0d want 10", nb); end
    n_cmp++; if (LO !== 32'h3) begin n_bad++; $display("FAIL divu_lo: got %h want 00000003", LO); end
    n_cmp++; if (HI !== 32'h1) begin n_bad++; $display("FAIL divu_hi: got %h want 00000001", HI); end
    // divu treats 0xFFFFFFF9 as unsigned: 4294967289 / 2 = 2147483644 rem 1
    run_op(3'b100, 32'hFFFFFFF9, 32'h2, nb);
    n_cmp++; if (LO !== 32'h7FFFFFFC) begin n_bad++; $display("FAIL divu_big_lo: got %h want 7ffffffc", LO); end
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, nb);
    n_cmp++; if (LO !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
    n_cmp++; if (HI !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
  endtask

  // HI=0, LO=0x80000000 on entry.
  task automatic test_mthi_mtlo();
    start = 1'b1; MDop = 3'b101; A = 32'h12345678; HILO_Rop = 2'b01; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mthi_no_bypass: got %h want 0", rdata); end
    @(negedge clk);
    start = 1'b0; MDop = 3'b000; A = '0; #1;
    n_cmp++; if (HI !== 32'h12345678) begin n_bad++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
    n_cmp++; if (rdata !== 32'h12345678) begin n_bad++; $display("FAIL mfhi_rdata: got %h want 12345678", rdata); end
    @(negedge clk);
    start = 1'b1; MDop = 3'b110; A = 32'hCAFEF00D; HILO_Rop = 2'b10; #1;
    n_cmp++; if (rdata !== 32'h80000000) begin n_bad++; $display("FAIL mtlo_no_bypass: got %h want 80000000", rdata); end
    @(negedge clk);
    start = 1'b0; MDop = 3'b000; A = '0; #1;
    n_cmp++; if (LO !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mtlo_lo: got %h want cafef00d", LO); end
    n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mflo_rdata: got %h want cafef00d", rdata); end
    n_cmp++; if (HI !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_keeps_hi: got %h want 12345678", HI); end
    HILO_Rop = 2'b00; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rop00_rdata: got %h want 0", rdata); end
    HILO_Rop = 2'b11; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rop11_rdata: got %h want 0", rdata); end
    HILO_Rop = 2'b00;
    @(negedge clk);
  endtask

  // LO=0xCAFEF00D on entry; mtlo and a div offered during busy must both be dropped.
  task automatic test_busy_ignore();
    int nb;
    start = 1'b1; MDop = 3'b010; A = 32'hFFFFFFFF; B = 32'h2;
    @(negedge clk);
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      nb++;
      if (nb == 1) begin start = 1'b1; MDop = 3'b110; A = 32'hAAAA5555; B = 32'h0; end
      else if (nb == 2) begin
        n_cmp++; if (LO !== 32'hCAFEF00D) begin n_bad++; $display("FAIL busy_mtlo_ignored: got %h want cafef00d", LO); end
        start = 1'b1; MDop = 3'b011; A = 32'd100; B = 32'd7;
      end else begin start = 1'b0; MDop = 3'b000; A = '0; B = '0; end
      @(negedge clk);
    end
    start = 1'b0; MDop = 3'b000; A = '0; B = '0;
    n_cmp++; if (nb !== 5) begin n_bad++; $display("FAIL busy_ignore_cycles: got %0d want 5", nb); end
    n_cmp++; if (LO !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL busy_ignore_lo: got %h want fffffffe", LO); end
    n_cmp++; if (HI !== 32'h1) begin n_bad++; $display("FAIL busy_ignore_hi: got %h want 00000001", HI); end
  endtask

  task automatic test_flush();
    int nb;
    start = 1'b1; flush = 1'b1; MDop = 3'b011; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; MDop = 3'b000; A = '0; B = '0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) nb++;
      @(negedge clk);
    end
    n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL flush_busy_cycles: got %0d want 0", nb); end
    n_cmp++; if (HI !== 32'h1) begin n_bad++; $display("FAIL flush_hi: got %h want 00000001", HI); end
    n_cmp++; if (LO !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL flush_lo: got %h want fffffffe", LO); end
  endtask

  task automatic test_div0();
    int nb;
    load_hilo(32'h11111111, 32'h11111111);
    run_op(3'b011, 32'd5, 32'd0, nb);
    n_cmp++; if (nb !== DIV0_CYC) begin n_bad++; $display("FAIL div0_busy_cycles: got %0d want %0d", nb, DIV0_CYC); end
    n_cmp++; if (HI !== 32'h11111111) begin n_bad++; $display("FAIL div0_hi: got %h want 11111111", HI); end
    n_cmp++; if (LO !== 32'h11111111) begin n_bad++; $display("FAIL div0_lo: got %h want 11111111", LO); end
    run_op(3'b100, 32'd9, 32'd0, nb);
    n_cmp++; if (nb !== DIV0_CYC) begin n_bad++; $display("FAIL divu0_busy_cycles: got %0d want %0d", nb, DIV0_CYC); end
    n_cmp++; if (HI !== 32'h11111111 || LO !== 32'h11111111) begin n_bad++; $display("FAIL divu0_hilo: got %h/%h want 11111111/11111111", HI, LO); end
  endtask

  // Second op issued in the very first non-busy cycle after the first.
  task automatic test_back_to_back();
    int nb;
    run_op(3'b010, 32'd3, 32'd5, nb);
    n_cmp++; if (LO !== 32'd15 || HI !== 32'h0) begin n_bad++; $display("FAIL b2b_first: got %h/%h want 00000000/0000000f", HI, LO); end
    run_op(3'b001, 32'hFFFFFFFD, 32'd5, nb);
    n_cmp++; if (nb !== 5) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 5", nb); end
    n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL b2b_hi: got %h want ffffffff", HI); end
    n_cmp++; if (LO !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL b2b_lo: got %h want fffffff1", LO); end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; MDop = 3'b001; A = 32'd7; B = 32'd9;
    @(negedge clk);
    start = 1'b0; MDop = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (HI !== 32'h0 || LO !== 32'h0) begin n_bad++; $display("FAIL abort_hilo: got %h/%h want 0/0", HI, LO); end
    repeat (8) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_later: got %b want 0", busy); end
    n_cmp++; if (HI !== 32'h0 || LO !== 32'h0) begin n_bad++; $display("FAIL abort_no_write: got %h/%h want 0/0", HI, LO); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; MDop = 3'b000;
    A = '0; B = '0; HILO_Rop = 2'b00;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_flush();
    test_div0();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
